// File: rtl/pc_pkg.sv
// Shared types and default sizing for the fetch-stage program counter.
package pc_pkg;

  localparam int unsigned PC_W       = 6;
  localparam int unsigned PC_OFF_W   = 4;
  localparam int unsigned PC_STACK_S = 4;

  // Priority-resolved source of the next PC value.
  typedef enum logic [2:0] {
    PC_HOLD,
    PC_RET,
    PC_CALL,
    PC_JUMP,
    PC_BRANCH,
    PC_INC
  } pc_sel_e;

endpackage

// File: rtl/pc_stack_if.sv
// Control/status bundle between the decoder and the PC/return-stack block.
// Optional PC_STICKY_ERR_EN adds the sticky stackErr status line.
interface pc_stack_if #(
  parameter int unsigned D  = pc_pkg::PC_W,
  parameter int unsigned OW = pc_pkg::PC_OFF_W,
  parameter int unsigned S  = pc_pkg::PC_STACK_S
);
  localparam int unsigned DW = $clog2(S + 1);

  logic          stall;
  logic          jumpEn;
  logic          branchEn;
  logic          callEn;
  logic          retEn;
  logic [D-1:0]  target;
  logic [OW-1:0] offset;
  logic [D-1:0]  programCounter;
  logic [DW-1:0] stackDepth;
  logic          stackFull;
  logic          stackEmpty;
  logic          stackOvf;
  logic          stackUnf;
`ifdef PC_STICKY_ERR_EN
  logic          stackErr;
`endif

  modport master (
    output stall, jumpEn, branchEn, callEn, retEn, target, offset,
    input  programCounter, stackDepth, stackFull, stackEmpty, stackOvf, stackUnf
`ifdef PC_STICKY_ERR_EN
    , input stackErr
`endif
  );

  modport slave (
    input  stall, jumpEn, branchEn, callEn, retEn, target, offset,
    output programCounter, stackDepth, stackFull, stackEmpty, stackOvf, stackUnf
`ifdef PC_STICKY_ERR_EN
    , output stackErr
`endif
  );

endinterface

// File: rtl/ret_stack.sv
// Return-address LIFO with depth tracking and registered overflow/underflow pulses.
module ret_stack import pc_pkg::*; #(
  parameter int unsigned D = PC_W,
  parameter int unsigned S = PC_STACK_S
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [D-1:0]             push_data,
  output logic [D-1:0]             top,
  output logic [$clog2(S+1)-1:0]   depth,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf,
  output logic                     unf
);

  localparam int unsigned DW = $clog2(S + 1);
  localparam int unsigned AW = (S > 1) ? $clog2(S) : 1;
  localparam logic [DW-1:0] DepthMax = DW'(S);

  logic [D-1:0]  mem_q [S];
  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          do_push, do_pop;
  logic [AW-1:0] top_idx;

  assign full    = (depth_q == DepthMax);
  assign empty   = (depth_q == '0);
  // Pop wins over a simultaneous push; a push while full is dropped.
  assign do_pop  = pop & ~empty;
  assign do_push = push & ~pop & ~full;
  assign top_idx = AW'(depth_q - DW'(1));

  always_comb begin
    depth_d = depth_q;
    if (do_pop) begin
      depth_d = depth_q - DW'(1);
    end else if (do_push) begin
      depth_d = depth_q + DW'(1);
    end
    ovf_d = push & ~pop & full;
    unf_d = pop & empty;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage carries no reset; validity is tracked solely by depth_q.
  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem_q[depth_q[AW-1:0]] <= push_data;
    end
  end

  assign top   = mem_q[top_idx];
  assign depth = depth_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: rtl/pc_stack.sv
// Fetch-stage program counter: priority next-PC mux, PC register and return stack.
// Optional PC_STICKY_ERR_EN adds a sticky stackErr output cleared only by reset.
module pc_stack import pc_pkg::*; #(
  parameter int unsigned D  = PC_W,
  parameter int unsigned OW = PC_OFF_W,
  parameter int unsigned S  = PC_STACK_S
) (
  input  logic       clk,
  input  logic       reset,
  pc_stack_if.slave  bus
);

  pc_sel_e               sel;
  logic [D-1:0]          pc_q, pc_d;
  logic [D-1:0]          pc_inc;
  logic signed [D-1:0]   off_ext;
  logic [D-1:0]          stack_top;
  logic                  push_req, pop_req;
  logic                  st_empty;

  assign pc_inc  = pc_q + D'(1);
  assign off_ext = D'(signed'(bus.offset));

  // Stack requests are qualified only by stall; ret_stack flags the error cases.
  assign pop_req  = ~bus.stall & bus.retEn;
  assign push_req = ~bus.stall & ~bus.retEn & bus.callEn;

  ret_stack #(
    .D (D),
    .S (S)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .pop       (pop_req),
    .push_data (pc_inc),
    .top       (stack_top),
    .depth     (bus.stackDepth),
    .full      (bus.stackFull),
    .empty     (st_empty),
    .ovf       (bus.stackOvf),
    .unf       (bus.stackUnf)
  );

  assign bus.stackEmpty = st_empty;

  always_comb begin
    sel = PC_INC;
    if (bus.stall) begin
      sel = PC_HOLD;
    end else if (bus.retEn) begin
      // Return from an empty stack degrades to a plain increment.
      sel = st_empty ? PC_INC : PC_RET;
    end else if (bus.callEn) begin
      sel = PC_CALL;
    end else if (bus.jumpEn) begin
      sel = PC_JUMP;
    end else if (bus.branchEn) begin
      sel = PC_BRANCH;
    end
  end

  always_comb begin
    pc_d = pc_inc;
    case (sel)
      PC_HOLD:   pc_d = pc_q;
      PC_RET:    pc_d = stack_top;
      PC_CALL:   pc_d = bus.target;
      PC_JUMP:   pc_d = bus.target;
      PC_BRANCH: pc_d = pc_q + off_ext;
      default:   pc_d = pc_inc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.programCounter = pc_q;

`ifdef PC_STICKY_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | bus.stackOvf | bus.stackUnf;
    end
  end

  assign bus.stackErr = err_q | bus.stackOvf | bus.stackUnf;
`endif

endmodule

// File: tb/tb_pc_stack.sv
// Randomised scoreboard bench for pc_stack against a queue-based reference model.
module tb_pc_stack;

  localparam int D = 6;
  localparam int OW = 4;
  localparam int S = 4;
  localparam int M = 1 << D;

  typedef struct {
    int pc;
    int depth;
    bit ovf;
    bit unf;
    bit err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  exp_t exp_q[$];
  int   m_pc;
  int   m_stack[$];
  bit   m_err;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_stack_if #(.D(D), .OW(OW), .S(S)) bus ();

  pc_stack #(.D(D), .OW(OW), .S(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic drive_idle();
    bus.stall    = 1'b0;
    bus.retEn    = 1'b0;
    bus.callEn   = 1'b0;
    bus.jumpEn   = 1'b0;
    bus.branchEn = 1'b0;
    bus.target   = '0;
    bus.offset   = '0;
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_stack.delete();
    m_err = 1'b0;
  endtask

  // Reference behaviour for one clock edge; queues the expected post-edge view.
  task automatic step_model(input bit st, input bit rt, input bit cl, input bit jp,
                            input bit br, input int tgt, input int off);
    exp_t e;
    e.ovf = 1'b0;
    e.unf = 1'b0;
    if (!st) begin
      if (rt) begin
        if (m_stack.size() > 0) begin
          m_pc = m_stack.pop_back();
        end else begin
          m_pc  = (m_pc + 1) % M;
          e.unf = 1'b1;
        end
      end else if (cl) begin
        if (m_stack.size() < S) m_stack.push_back((m_pc + 1) % M);
        else e.ovf = 1'b1;
        m_pc = tgt % M;
      end else if (jp) begin
        m_pc = tgt % M;
      end else if (br) begin
        int so;
        so = off % (1 << OW);
        if (so >= (1 << (OW - 1))) so -= (1 << OW);
        m_pc = (m_pc + so + M) % M;
      end else begin
        m_pc = (m_pc + 1) % M;
      end
    end
    if (e.ovf || e.unf) m_err = 1'b1;
    e.pc    = m_pc;
    e.depth = m_stack.size();
    e.err   = m_err;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit st, input bit rt, input bit cl, input bit jp,
                     input bit br, input int tgt, input int off);
    @(negedge clk);
    bus.stall    = st;
    bus.retEn    = rt;
    bus.callEn   = cl;
    bus.jumpEn   = jp;
    bus.branchEn = br;
    bus.target   = tgt[D-1:0];
    bus.offset   = off[OW-1:0];
    step_model(st, rt, cl, jp, br, tgt, off);
  endtask

  // Reset raised between edges must clear state with no clock edge in between.
  task automatic async_reset(input bit with_call);
    @(negedge clk);
    bus.callEn = with_call;
    bus.target = D'(50);
    #2 reset = 1'b1;
    #1;
    check("async_rst_pc", bus.programCounter, 0);
    check("async_rst_depth", bus.stackDepth, 0);
    check("async_rst_empty", bus.stackEmpty, 1);
    check("async_rst_ovf", bus.stackOvf, 0);
    check("async_rst_unf", bus.stackUnf, 0);
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    model_reset();
    step_model(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one expected entry per modelled edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("pc", bus.programCounter, e.pc);
        check("depth", bus.stackDepth, e.depth);
        check("full", bus.stackFull, (e.depth == S) ? 1 : 0);
        check("empty", bus.stackEmpty, (e.depth == 0) ? 1 : 0);
        check("ovf", bus.stackOvf, e.ovf);
        check("unf", bus.stackUnf, e.unf);
`ifdef PC_STICKY_ERR_EN
        check("err", bus.stackErr, e.err);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive_idle();
    model_reset();
    #1;
    check("init_rst_pc", bus.programCounter, 0);
    check("init_rst_depth", bus.stackDepth, 0);
    @(negedge clk);
    reset = 1'b0;
    step_model(0, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);

    cyc(0, 0, 1, 0, 0, 20, 0);
    async_reset(1'b0);
    cyc(0, 0, 1, 0, 0, 22, 0);
    async_reset(1'b1);

    // Wrap and stall priority.
    cyc(0, 0, 0, 1, 0, 62, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 9, 0);

    // Relative branches, negative and wrapping.
    cyc(0, 0, 0, 1, 0, 10, 0);
    cyc(0, 0, 0, 0, 1, 0, 4'b1100);
    cyc(0, 0, 0, 1, 0, 60, 0);
    cyc(0, 0, 0, 0, 1, 0, 7);

    // Call / return.
    cyc(0, 0, 0, 1, 0, 5, 0);
    cyc(0, 0, 1, 0, 0, 20, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);

    // Overflow then LIFO drain.
    repeat (5) cyc(0, 0, 1, 0, 0, 30, 0);
    repeat (4) cyc(0, 1, 0, 0, 0, 0, 0);

    // Underflow and call/return collision.
    cyc(0, 0, 0, 1, 0, 12, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 39, 0);
    cyc(0, 0, 1, 0, 0, 40, 0);
    cyc(0, 1, 1, 0, 0, 20, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        async_reset(r == 0);
      end else begin
        cyc($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) == 0, int'($urandom_range(0, M - 1)),
            int'($urandom_range(0, (1 << OW) - 1)));
      end
    end

    @(negedge clk);
    drive_idle();
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
